// File: rtl/boot_bus_pkg.sv
// Shared types and constants for the boot memory arbiter: FSM states, requester
// ids and the geometry of the boot ROM window.
package boot_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_id_t;

  localparam logic [15:0] ROM_BASE_DEFAULT = 16'hFF00;
  localparam int          ROM_SIZE         = 256;
  localparam int          ROM_AW           = $clog2(ROM_SIZE);

endpackage

// File: rtl/boot_bus_arb_if.sv
// Bundle of both requester ports plus the memory-side port of the boot arbiter.
// slave is the arbiter's view; master is the requesters'/memories' view.
interface boot_bus_arb_if #(
  parameter int AW = 16
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_a;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          cpu_err;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_a;
  logic [7:0]    dbg_din;
  logic [7:0]    dbg_dout;
  logic          dbg_ack;
  logic          dbg_err;

  logic          rom_sel;
  logic          ram_sel;
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [7:0]    mem_din;
  logic [7:0]    rom_dout;
  logic [7:0]    ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_a, cpu_din,
    output cpu_dout, cpu_ack, cpu_err,
    input  dbg_req, dbg_we, dbg_a, dbg_din,
    output dbg_dout, dbg_ack, dbg_err,
    output rom_sel, ram_sel, mem_a, mem_we, mem_din,
    input  rom_dout, ram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_a, cpu_din,
    input  cpu_dout, cpu_ack, cpu_err,
    output dbg_req, dbg_we, dbg_a, dbg_din,
    input  dbg_dout, dbg_ack, dbg_err,
    input  rom_sel, ram_sel, mem_a, mem_we, mem_din,
    output rom_dout, ram_dout
  );

endinterface

// File: rtl/boot_bus_rr.sv
// Two-way round-robin picker. The pointer remembers the last granted port so
// that, under contention, the other port wins next.
module boot_bus_rr
  import boot_bus_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic     valid,
  output port_id_t id
);

  logic [1:0] cand;
  port_id_t   last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cand
      assign cand[gi] = req[gi] & ~mask[gi];
    end
  endgenerate

  always_comb begin
    valid = en & (|cand);
    id    = PORT_CPU;
    if (cand == 2'b11) begin
      id = (last_reg == PORT_CPU) ? PORT_DBG : PORT_CPU;
    end else if (cand[1]) begin
      id = PORT_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= PORT_DBG;
    end else if (valid) begin
      last_reg <= id;
    end
  end

endmodule

// File: rtl/boot_bus_arb.sv
// Boot memory arbiter: round-robin grant between CPU and debug port, programmable
// wait states, ROM/RAM decode, one-cycle ack and dropped ROM-window writes.
module boot_bus_arb
  import boot_bus_pkg::*;
#(
  parameter int          AW       = 16,
  parameter int unsigned WAIT     = 1,
  parameter logic [AW-1:0] ROM_BASE = ROM_BASE_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  boot_bus_arb_if.slave  bus
);

  state_t        state_reg, state_next;
  port_id_t      winner_reg, gnt_id;
  logic          gnt_valid, arb_en;
  logic [1:0]    arb_req, arb_mask;
  logic          we_reg;
  logic [AW-1:0] a_reg;
  logic [7:0]    din_reg;
  logic [3:0]    cnt_reg;
  logic [7:0]    cpu_dout_reg, dbg_dout_reg;
  logic          in_rom, capture;
  logic          rom_sel, ram_sel, mem_we;
  logic          cpu_ack, dbg_ack, cpu_err, dbg_err;

  assign in_rom  = (a_reg[AW-1:ROM_AW] == ROM_BASE[AW-1:ROM_AW]);
  assign arb_req = {bus.dbg_req, bus.cpu_req};
  assign arb_en  = (state_reg != ACCESS);
  // The port being acked still holds req this cycle, so it must not re-win.
  assign arb_mask = (state_reg != DONE)       ? 2'b00 :
                    (winner_reg == PORT_DBG)  ? 2'b10 : 2'b01;
  assign capture = (state_reg == ACCESS) && (cnt_reg == 4'd0);

  boot_bus_rr u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (arb_req),
    .mask  (arb_mask),
    .valid (gnt_valid),
    .id    (gnt_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rom_sel    = 1'b0;
    ram_sel    = 1'b0;
    mem_we     = 1'b0;
    cpu_ack    = 1'b0;
    dbg_ack    = 1'b0;
    cpu_err    = 1'b0;
    dbg_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_valid) state_next = ACCESS;
      end
      ACCESS: begin
        rom_sel = in_rom;
        ram_sel = ~in_rom;
        mem_we  = we_reg & ~in_rom;
        if (cnt_reg == 4'd0) state_next = DONE;
      end
      DONE: begin
        state_next = gnt_valid ? ACCESS : IDLE;
        if (winner_reg == PORT_DBG) begin
          dbg_ack = 1'b1;
          dbg_err = we_reg & in_rom;
        end else begin
          cpu_ack = 1'b1;
          cpu_err = we_reg & in_rom;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter and per-port read data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_reg   <= PORT_DBG;
      we_reg       <= 1'b0;
      a_reg        <= '0;
      din_reg      <= '0;
      cnt_reg      <= '0;
      cpu_dout_reg <= '0;
      dbg_dout_reg <= '0;
    end else begin
      if (gnt_valid) begin
        winner_reg <= gnt_id;
        we_reg     <= (gnt_id == PORT_DBG) ? bus.dbg_we  : bus.cpu_we;
        a_reg      <= (gnt_id == PORT_DBG) ? bus.dbg_a   : bus.cpu_a;
        din_reg    <= (gnt_id == PORT_DBG) ? bus.dbg_din : bus.cpu_din;
        cnt_reg    <= 4'(WAIT);
      end else if (state_reg == ACCESS && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (capture && !we_reg) begin
        if (winner_reg == PORT_DBG) begin
          dbg_dout_reg <= in_rom ? bus.rom_dout : bus.ram_dout;
        end else begin
          cpu_dout_reg <= in_rom ? bus.rom_dout : bus.ram_dout;
        end
      end
    end
  end

  assign bus.rom_sel  = rom_sel;
  assign bus.ram_sel  = ram_sel;
  assign bus.mem_we   = mem_we;
  assign bus.mem_a    = a_reg;
  assign bus.mem_din  = din_reg;
  assign bus.cpu_ack  = cpu_ack;
  assign bus.cpu_err  = cpu_err;
  assign bus.cpu_dout = cpu_dout_reg;
  assign bus.dbg_ack  = dbg_ack;
  assign bus.dbg_err  = dbg_err;
  assign bus.dbg_dout = dbg_dout_reg;

endmodule

// File: tb/tb_boot_bus_arb.sv
// Bench for boot_bus_arb: three instances (WAIT=1, 0, 3) with ROM/RAM models,
// scenario tasks and a scoreboard queue of expected completions.
module tb_boot_bus_arb;

  localparam int N = 3;

  typedef struct {
    bit         dbg;
    logic [7:0] dout;
    logic       err;
    int         lat;
    int         nrom;
    int         nram;
    int         nwe;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  logic        cpu_req [N];
  logic        cpu_we  [N];
  logic [15:0] cpu_a   [N];
  logic [7:0]  cpu_din [N];
  logic        dbg_req [N];
  logic        dbg_we  [N];
  logic [15:0] dbg_a   [N];
  logic [7:0]  dbg_din [N];

  logic        cpu_ack [N];
  logic        cpu_err [N];
  logic [7:0]  cpu_dout[N];
  logic        dbg_ack [N];
  logic        dbg_err [N];
  logic [7:0]  dbg_dout[N];
  logic        rom_sel [N];
  logic        ram_sel [N];
  logic        mem_we  [N];
  logic [15:0] mem_a   [N];
  logic [7:0]  mem_din [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unit
      localparam int unsigned W = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
      boot_bus_arb_if #(.AW(16)) bus ();
      logic [7:0] ram [0:65535];

      assign bus.cpu_req  = cpu_req[gi];
      assign bus.cpu_we   = cpu_we[gi];
      assign bus.cpu_a    = cpu_a[gi];
      assign bus.cpu_din  = cpu_din[gi];
      assign bus.dbg_req  = dbg_req[gi];
      assign bus.dbg_we   = dbg_we[gi];
      assign bus.dbg_a    = dbg_a[gi];
      assign bus.dbg_din  = dbg_din[gi];
      // ROM image: each byte holds its offset plus one.
      assign bus.rom_dout = bus.mem_a[7:0] + 8'h01;
      assign bus.ram_dout = ram[bus.mem_a];
      always @(posedge clk) if (bus.mem_we) ram[bus.mem_a] <= bus.mem_din;

      assign cpu_ack[gi]  = bus.cpu_ack;
      assign cpu_err[gi]  = bus.cpu_err;
      assign cpu_dout[gi] = bus.cpu_dout;
      assign dbg_ack[gi]  = bus.dbg_ack;
      assign dbg_err[gi]  = bus.dbg_err;
      assign dbg_dout[gi] = bus.dbg_dout;
      assign rom_sel[gi]  = bus.rom_sel;
      assign ram_sel[gi]  = bus.ram_sel;
      assign mem_we[gi]   = bus.mem_we;
      assign mem_a[gi]    = bus.mem_a;
      assign mem_din[gi]  = bus.mem_din;

      boot_bus_arb #(.AW(16), .WAIT(W), .ROM_BASE(16'hFF00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );
    end
  endgenerate

  function automatic logic [46:0] outs(input int u);
    return {cpu_ack[u], cpu_err[u], dbg_ack[u], dbg_err[u], rom_sel[u], ram_sel[u],
            mem_we[u], mem_a[u], mem_din[u], cpu_dout[u], dbg_dout[u]};
  endfunction

  // Drive one transaction, wait (bounded) for its ack, report what was seen.
  task automatic xfer(input int u, input bit dbg, input logic we, input logic [15:0] a,
                      input logic [7:0] d, output bit got, output int lat, output int at,
                      output logic [7:0] dout, output logic err,
                      output int nrom, output int nram, output int nwe);
    int start;
    got = 0; lat = -1; at = -1; dout = '0; err = 1'b0; nrom = 0; nram = 0; nwe = 0;
    if (dbg) begin
      dbg_we[u] = we; dbg_a[u] = a; dbg_din[u] = d; dbg_req[u] = 1'b1;
    end else begin
      cpu_we[u] = we; cpu_a[u] = a; cpu_din[u] = d; cpu_req[u] = 1'b1;
    end
    start = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rom_sel[u]) nrom++;
      if (ram_sel[u]) nram++;
      if (mem_we[u])  nwe++;
      if (dbg ? dbg_ack[u] : cpu_ack[u]) begin
        got  = 1;
        lat  = cyc - start;
        at   = cyc;
        dout = dbg ? dbg_dout[u] : cpu_dout[u];
        err  = dbg ? dbg_err[u] : cpu_err[u];
      end
    end
    $display("txn u%0d %s %s a=%h d=%h dout=%h err=%0d lat=%0d acked=%0d",
             u, dbg ? "dbg" : "cpu", we ? "wr" : "rd", a, d, dout, err, lat, got);
    @(posedge clk); #1;
    if (dbg) dbg_req[u] = 1'b0; else cpu_req[u] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    for (int u = 0; u < N; u++) begin
      checks++;
      if (outs(u) !== 47'd0) begin
        errors++; $display("FAIL reset_outputs u%0d: got %h want 0", u, outs(u));
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Run a list of transactions on one port back to back against the scoreboard.
  task automatic run_list(input string name, input int u, input bit dbg, input int n,
                          input logic [15:0] a_l [4], input logic w_l [4],
                          input logic [7:0] d_l [4], input int gap);
    bit got; int lat, at, prev, nrom, nram, nwe; logic [7:0] dout; logic err; exp_t e;
    prev = -1;
    for (int i = 0; i < n; i++) begin
      xfer(u, dbg, w_l[i], a_l[i], d_l[i], got, lat, at, dout, err, nrom, nram, nwe);
      e = sb.pop_front();
      checks++;
      if (!got || lat !== e.lat) begin
        errors++; $display("FAIL %s[%0d] latency: got %0d (acked=%0d) want %0d", name, i, lat, got, e.lat);
      end
      checks++;
      if (dout !== e.dout || err !== e.err) begin
        errors++; $display("FAIL %s[%0d] data: got dout=%h err=%0d want dout=%h err=%0d",
                           name, i, dout, err, e.dout, e.err);
      end
      checks++;
      if (nrom !== e.nrom || nram !== e.nram || nwe !== e.nwe) begin
        errors++; $display("FAIL %s[%0d] selects: got rom=%0d ram=%0d we=%0d want rom=%0d ram=%0d we=%0d",
                           name, i, nrom, nram, nwe, e.nrom, e.nram, e.nwe);
      end
      if (gap > 0 && prev >= 0) begin
        checks++;
        if (at - prev !== gap) begin
          errors++; $display("FAIL %s[%0d] ack spacing: got %0d want %0d", name, i, at - prev, gap);
        end
      end
      prev = at;
    end
  endtask

  task automatic test_rom_read();
    logic [15:0] a_l [4]; logic w_l [4]; logic [7:0] d_l [4];
    a_l = '{16'hFFFE, 16'h0, 16'h0, 16'h0}; w_l = '{0, 0, 0, 0}; d_l = '{8'h0, 8'h0, 8'h0, 8'h0};
    sb.push_back('{dbg: 0, dout: 8'hFF, err: 0, lat: 3, nrom: 2, nram: 0, nwe: 0});
    run_list("rom_read", 0, 0, 1, a_l, w_l, d_l, 0);
  endtask

  task automatic test_ram_write_read();
    logic [15:0] a_l [4]; logic w_l [4]; logic [7:0] d_l [4];
    a_l = '{16'h0100, 16'h0100, 16'h0, 16'h0}; w_l = '{1, 0, 0, 0}; d_l = '{8'h5A, 8'h00, 8'h0, 8'h0};
    sb.push_back('{dbg: 0, dout: 8'hFF, err: 0, lat: 3, nrom: 0, nram: 2, nwe: 2});
    sb.push_back('{dbg: 0, dout: 8'h5A, err: 0, lat: 3, nrom: 0, nram: 2, nwe: 0});
    run_list("ram_wr_rd", 0, 0, 2, a_l, w_l, d_l, 0);
  endtask

  task automatic test_rom_write();
    logic [15:0] a_l [4]; logic w_l [4]; logic [7:0] d_l [4];
    a_l = '{16'hFF10, 16'hFF10, 16'h0, 16'h0}; w_l = '{1, 0, 0, 0}; d_l = '{8'h77, 8'h00, 8'h0, 8'h0};
    sb.push_back('{dbg: 1, dout: 8'h00, err: 1, lat: 3, nrom: 2, nram: 0, nwe: 0});
    sb.push_back('{dbg: 1, dout: 8'h11, err: 0, lat: 3, nrom: 2, nram: 0, nwe: 0});
    run_list("rom_write", 0, 1, 2, a_l, w_l, d_l, 0);
  endtask

  task automatic test_alternate();
    exp_t e; int last, n;
    do_reset();
    @(posedge clk); #1;
    cpu_we[0] = 0; cpu_a[0] = 16'hFFFE; dbg_we[0] = 0; dbg_a[0] = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      e = '{dbg: (i % 2 == 1), dout: (i % 2 == 1) ? 8'h5A : 8'hFF, err: 0, lat: 3, nrom: 0, nram: 0, nwe: 0};
      sb.push_back(e);
    end
    cpu_req[0] = 1'b1; dbg_req[0] = 1'b1;
    last = cyc; n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (cpu_ack[0] || dbg_ack[0]) begin
        e = sb.pop_front();
        $display("txn u0 alternate ack cpu=%0d dbg=%0d cyc=%0d", cpu_ack[0], dbg_ack[0], cyc);
        checks++;
        if (dbg_ack[0] !== e.dbg || cpu_ack[0] === dbg_ack[0]) begin
          errors++; $display("FAIL alt_order[%0d]: got cpu_ack=%0d dbg_ack=%0d want dbg=%0d",
                             n, cpu_ack[0], dbg_ack[0], e.dbg);
        end
        checks++;
        if ((e.dbg ? dbg_dout[0] : cpu_dout[0]) !== e.dout) begin
          errors++; $display("FAIL alt_data[%0d]: got %h want %h", n,
                             e.dbg ? dbg_dout[0] : cpu_dout[0], e.dout);
        end
        checks++;
        if (cyc - last !== e.lat) begin
          errors++; $display("FAIL alt_spacing[%0d]: got %0d want %0d", n, cyc - last, e.lat);
        end
        last = cyc; n++;
      end
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL alt_count: got %0d acks want 4", n);
    end
    @(posedge clk); #1;
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
    sb.delete();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a_l [4]; logic w_l [4]; logic [7:0] d_l [4];
    a_l = '{16'hFEFF, 16'hFEFF, 16'hFF00, 16'hFFFF};
    w_l = '{1, 0, 0, 0};
    d_l = '{8'h3C, 8'h00, 8'h00, 8'h00};
    sb.push_back('{dbg: 0, dout: 8'h00, err: 0, lat: 2, nrom: 0, nram: 1, nwe: 1});
    sb.push_back('{dbg: 0, dout: 8'h3C, err: 0, lat: 2, nrom: 0, nram: 1, nwe: 0});
    sb.push_back('{dbg: 0, dout: 8'h01, err: 0, lat: 2, nrom: 1, nram: 0, nwe: 0});
    sb.push_back('{dbg: 0, dout: 8'h00, err: 0, lat: 2, nrom: 1, nram: 0, nwe: 0});
    run_list("b2b_w0", 1, 0, 4, a_l, w_l, d_l, 3);
  endtask

  task automatic test_wait3();
    logic [15:0] a_l [4]; logic w_l [4]; logic [7:0] d_l [4];
    a_l = '{16'hFF20, 16'h0, 16'h0, 16'h0}; w_l = '{0, 0, 0, 0}; d_l = '{8'h0, 8'h0, 8'h0, 8'h0};
    sb.push_back('{dbg: 0, dout: 8'h21, err: 0, lat: 5, nrom: 4, nram: 0, nwe: 0});
    run_list("wait3", 2, 0, 1, a_l, w_l, d_l, 0);
  endtask

  task automatic test_reset_mid();
    int start, acks; bit got; exp_t e;
    sb.push_back('{dbg: 0, dout: 8'h31, err: 0, lat: 5, nrom: 0, nram: 0, nwe: 0});
    @(posedge clk); #1;
    cpu_we[2] = 0; cpu_a[2] = 16'hFF30; cpu_req[2] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rom_sel[2] !== 1'b1) begin
      errors++; $display("FAIL midrst_in_access: got rom_sel=%0d want 1", rom_sel[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs(2) !== 47'd0) begin
      errors++; $display("FAIL midrst_outputs: got %h want 0", outs(2));
    end
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack[2] || dbg_ack[2]) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL midrst_no_ack: got %0d acks want 0", acks);
    end
    rst_n = 1'b1;
    start = cyc; got = 0;
    e = sb.pop_front();
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack[2]) begin
        got = 1;
        $display("txn u2 cpu rd a=ff30 after reset dout=%h lat=%0d", cpu_dout[2], cyc - start);
        checks++;
        if (cpu_dout[2] !== e.dout || cyc - start !== e.lat) begin
          errors++; $display("FAIL midrst_regrant: got dout=%h lat=%0d want dout=%h lat=%0d",
                             cpu_dout[2], cyc - start, e.dout, e.lat);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL midrst_timeout: got no ack want ack");
    end
    @(posedge clk); #1;
    cpu_req[2] = 1'b0;
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    for (int u = 0; u < N; u++) begin
      cpu_req[u] = 0; cpu_we[u] = 0; cpu_a[u] = '0; cpu_din[u] = '0;
      dbg_req[u] = 0; dbg_we[u] = 0; dbg_a[u] = '0; dbg_din[u] = '0;
    end
    test_reset();
    test_rom_read();
    test_ram_write_read();
    test_rom_write();
    test_alternate();
    test_back_to_back();
    test_wait3();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
